// File: rtl/rom_read_arbiter.sv
// Two-master to one-slave AXI read arbiter in front of the boot ROM port.
// Optional counters are enabled by defining ROM_ARB_PERF_EN.
module rom_read_arbiter #(
   parameter int IDM_W = 4,
   parameter int IDS_W = 8,
   parameter int CNT_W = 32
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   input  logic [IDM_W-1:0] M0_ARID,
   input  logic [31:0]      M0_ARADDR,
   input  logic [3:0]       M0_ARLEN,
   input  logic [2:0]       M0_ARSIZE,
   input  logic [1:0]       M0_ARBURST,
   input  logic             M0_ARVALID,
   output logic             M0_ARREADY,
   output logic [IDM_W-1:0] M0_RID,
   output logic [31:0]      M0_RDATA,
   output logic [1:0]       M0_RRESP,
   output logic             M0_RLAST,
   output logic             M0_RVALID,
   input  logic             M0_RREADY,
   input  logic [IDM_W-1:0] M1_ARID,
   input  logic [31:0]      M1_ARADDR,
   input  logic [3:0]       M1_ARLEN,
   input  logic [2:0]       M1_ARSIZE,
   input  logic [1:0]       M1_ARBURST,
   input  logic             M1_ARVALID,
   output logic             M1_ARREADY,
   output logic [IDM_W-1:0] M1_RID,
   output logic [31:0]      M1_RDATA,
   output logic [1:0]       M1_RRESP,
   output logic             M1_RLAST,
   output logic             M1_RVALID,
   input  logic             M1_RREADY,
   output logic [IDS_W-1:0] S_ARID,
   output logic [31:0]      S_ARADDR,
   output logic [3:0]       S_ARLEN,
   output logic [2:0]       S_ARSIZE,
   output logic [1:0]       S_ARBURST,
   output logic             S_ARVALID,
   input  logic             S_ARREADY,
   input  logic [IDS_W-1:0] S_RID,
   input  logic [31:0]      S_RDATA,
   input  logic [1:0]       S_RRESP,
   input  logic             S_RLAST,
   input  logic             S_RVALID,
   output logic             S_RREADY
`ifdef ROM_ARB_PERF_EN
  ,output logic [CNT_W-1:0] PERF_GNT0,
   output logic [CNT_W-1:0] PERF_GNT1,
   output logic [CNT_W-1:0] PERF_STALL
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   gnt_q, gnt_d;
   logic   prio_q, prio_d;

   logic             sel_arvalid;
   logic             sel_rready;
   logic             ar_hs;
   logic             r_end;
   logic [IDS_W-1:0] s_arid;
   logic             unused_rid;

   assign sel_arvalid = gnt_q ? M1_ARVALID : M0_ARVALID;
   assign sel_rready  = gnt_q ? M1_RREADY : M0_RREADY;
   assign ar_hs = (state_q == ADDR) & sel_arvalid & S_ARREADY;
   assign r_end = (state_q == DATA) & S_RVALID
                & sel_rready & S_RLAST;

   // Upper slave ID bits only carry the routing tag; replies are
   // routed by the held grant instead.
   assign unused_rid = ^S_RID[IDS_W-1:IDM_W];

   always_comb begin
      s_arid = '0;
      s_arid[IDM_W-1:0] = gnt_q ? M1_ARID : M0_ARID;
      s_arid[IDM_W] = gnt_q;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         prio_q  <= prio_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      prio_d     = prio_q;
      M0_ARREADY = 1'b0;
      M1_ARREADY = 1'b0;
      M0_RID     = '0;
      M0_RDATA   = '0;
      M0_RRESP   = '0;
      M0_RLAST   = 1'b0;
      M0_RVALID  = 1'b0;
      M1_RID     = '0;
      M1_RDATA   = '0;
      M1_RRESP   = '0;
      M1_RLAST   = 1'b0;
      M1_RVALID  = 1'b0;
      S_ARID     = '0;
      S_ARADDR   = '0;
      S_ARLEN    = '0;
      S_ARSIZE   = '0;
      S_ARBURST  = '0;
      S_ARVALID  = 1'b0;
      S_RREADY   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (M0_ARVALID | M1_ARVALID) begin
               gnt_d = (M0_ARVALID & M1_ARVALID)
                     ? prio_q : M1_ARVALID;
               state_d = ADDR;
            end
         end
         ADDR: begin
            S_ARID    = s_arid;
            S_ARADDR  = gnt_q ? M1_ARADDR : M0_ARADDR;
            S_ARLEN   = gnt_q ? M1_ARLEN : M0_ARLEN;
            S_ARSIZE  = gnt_q ? M1_ARSIZE : M0_ARSIZE;
            S_ARBURST = gnt_q ? M1_ARBURST : M0_ARBURST;
            S_ARVALID = sel_arvalid;
            M0_ARREADY = ~gnt_q & S_ARREADY;
            M1_ARREADY = gnt_q & S_ARREADY;
            if (ar_hs)
               state_d = DATA;
         end
         DATA: begin
            S_RREADY = sel_rready;
            if (gnt_q) begin
               M1_RID    = S_RID[IDM_W-1:0];
               M1_RDATA  = S_RDATA;
               M1_RRESP  = S_RRESP;
               M1_RLAST  = S_RLAST;
               M1_RVALID = S_RVALID;
            end else begin
               M0_RID    = S_RID[IDM_W-1:0];
               M0_RDATA  = S_RDATA;
               M0_RRESP  = S_RRESP;
               M0_RLAST  = S_RLAST;
               M0_RVALID = S_RVALID;
            end
            if (r_end) begin
               state_d = IDLE;
               prio_d  = ~gnt_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef ROM_ARB_PERF_EN
   logic [CNT_W-1:0] gnt0_q, gnt0_d;
   logic [CNT_W-1:0] gnt1_q, gnt1_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             other_wait;

   assign other_wait = (state_q != IDLE)
                     & (gnt_q ? M0_ARVALID : M1_ARVALID);

   // All counters stick at all-ones instead of wrapping.
   always_comb begin
      gnt0_d  = gnt0_q;
      gnt1_d  = gnt1_q;
      stall_d = stall_q;
      if (ar_hs & ~gnt_q & ~&gnt0_q)
         gnt0_d = gnt0_q + CNT_W'(1);
      if (ar_hs & gnt_q & ~&gnt1_q)
         gnt1_d = gnt1_q + CNT_W'(1);
      if (other_wait & ~&stall_q)
         stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         gnt0_q  <= '0;
         gnt1_q  <= '0;
         stall_q <= '0;
      end else begin
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         stall_q <= stall_d;
      end
   end

   assign PERF_GNT0  = gnt0_q;
   assign PERF_GNT1  = gnt1_q;
   assign PERF_STALL = stall_q;
`else
   logic [CNT_W-1:0] unused_cnt;
   assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: a bus model drives masters and
// the ROM slave; monitors pop expected AR and R beats from queues.
module tb_rom_read_arbiter;

   logic        ACLK;
   logic        ARESETn;
   logic [3:0]  M0_ARID, M1_ARID;
   logic [31:0] M0_ARADDR, M1_ARADDR;
   logic [3:0]  M0_ARLEN, M1_ARLEN;
   logic [2:0]  M0_ARSIZE, M1_ARSIZE;
   logic [1:0]  M0_ARBURST, M1_ARBURST;
   logic        M0_ARVALID, M1_ARVALID;
   logic        M0_ARREADY, M1_ARREADY;
   logic [3:0]  M0_RID, M1_RID;
   logic [31:0] M0_RDATA, M1_RDATA;
   logic [1:0]  M0_RRESP, M1_RRESP;
   logic        M0_RLAST, M1_RLAST;
   logic        M0_RVALID, M1_RVALID;
   logic        M0_RREADY, M1_RREADY;
   logic [7:0]  S_ARID;
   logic [31:0] S_ARADDR;
   logic [3:0]  S_ARLEN;
   logic [2:0]  S_ARSIZE;
   logic [1:0]  S_ARBURST;
   logic        S_ARVALID;
   logic        S_ARREADY;
   logic [7:0]  S_RID;
   logic [31:0] S_RDATA;
   logic [1:0]  S_RRESP;
   logic        S_RLAST;
   logic        S_RVALID;
   logic        S_RREADY;
`ifdef ROM_ARB_PERF_EN
   logic [31:0] PERF_GNT0, PERF_GNT1, PERF_STALL;
`endif

   rom_read_arbiter dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .M0_ARID(M0_ARID), .M0_ARADDR(M0_ARADDR),
      .M0_ARLEN(M0_ARLEN), .M0_ARSIZE(M0_ARSIZE),
      .M0_ARBURST(M0_ARBURST), .M0_ARVALID(M0_ARVALID),
      .M0_ARREADY(M0_ARREADY), .M0_RID(M0_RID),
      .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP),
      .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID),
      .M0_RREADY(M0_RREADY),
      .M1_ARID(M1_ARID), .M1_ARADDR(M1_ARADDR),
      .M1_ARLEN(M1_ARLEN), .M1_ARSIZE(M1_ARSIZE),
      .M1_ARBURST(M1_ARBURST), .M1_ARVALID(M1_ARVALID),
      .M1_ARREADY(M1_ARREADY), .M1_RID(M1_RID),
      .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP),
      .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID),
      .M1_RREADY(M1_RREADY),
      .S_ARID(S_ARID), .S_ARADDR(S_ARADDR),
      .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
      .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID),
      .S_ARREADY(S_ARREADY), .S_RID(S_RID),
      .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
      .S_RLAST(S_RLAST), .S_RVALID(S_RVALID),
      .S_RREADY(S_RREADY)
`ifdef ROM_ARB_PERF_EN
     ,.PERF_GNT0(PERF_GNT0), .PERF_GNT1(PERF_GNT1),
      .PERF_STALL(PERF_STALL)
`endif
   );

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
   } req_t;

   typedef struct {
      logic [7:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
   } ar_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  id;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   req_t  q0[$], q1[$];
   ar_t   ar_exp[$];
   beat_t rexp0[$], rexp1[$];

   int total = 0;
   int bad = 0;
   int m0_cnt = 0;
   int m1_cnt = 0;

   wire any_out = |{M0_ARREADY, M0_RID, M0_RDATA, M0_RRESP,
                    M0_RLAST, M0_RVALID, M1_ARREADY, M1_RID,
                    M1_RDATA, M1_RRESP, M1_RLAST, M1_RVALID,
                    S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE,
                    S_ARBURST, S_ARVALID, S_RREADY};

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic issue(input int m, input logic [3:0] id,
                        input logic [31:0] addr,
                        input logic [3:0] len);
      req_t  r;
      beat_t b;
      r.id = id;
      r.addr = addr;
      r.len = len;
      if (m == 0) q0.push_back(r);
      else q1.push_back(r);
      for (int i = 0; i <= int'(len); i++) begin
         b.data = 32'hA000_0000 + addr + 32'(i * 4);
         b.id   = id;
         b.resp = (addr == 32'h3000) ? 2'b11 : 2'b00;
         b.last = (i == int'(len));
         if (m == 0) rexp0.push_back(b);
         else rexp1.push_back(b);
      end
   endtask

   task automatic expect_ar(input logic g, input logic [3:0] id,
                            input logic [31:0] addr,
                            input logic [3:0] len);
      ar_t a;
      a.id = {3'b000, g, id};
      a.addr = addr;
      a.len = len;
      ar_exp.push_back(a);
   endtask

   task automatic wait_idle(input string nm);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge ACLK); #1;
         done = (ar_exp.size() == 0) && (rexp0.size() == 0)
             && (rexp1.size() == 0) && !M0_ARVALID
             && !M1_ARVALID && !S_RVALID;
      end
      chk({nm, "_done"}, done, 1);
      @(negedge ACLK); #1;
      chk({nm, "_idle"},
          {S_ARVALID, S_RREADY, M0_ARREADY, M1_ARREADY}, 0);
   endtask

   task automatic reset_pulse();
      @(posedge ACLK); #2;
      ARESETn = 1'b0;
      repeat (2) @(posedge ACLK);
      #2;
      ARESETn = 1'b1;
   endtask

   // Bus model: master AR drivers plus a ROM slave with one outstanding burst.
   initial begin
      int       beat;
      logic [7:0]  sl_id;
      logic [31:0] sl_addr;
      logic [3:0]  sl_len;
      logic ar_hs, r_hs, m0_hs, m1_hs;
      logic [7:0]  c_id;
      logic [31:0] c_addr;
      logic [3:0]  c_len;
      req_t r;
      beat = 0; sl_id = 0; sl_addr = 0; sl_len = 0;
      M0_ARVALID = 0; M1_ARVALID = 0;
      M0_ARID = 0; M0_ARADDR = 0; M0_ARLEN = 0;
      M1_ARID = 0; M1_ARADDR = 0; M1_ARLEN = 0;
      M0_ARSIZE = 3'd2; M1_ARSIZE = 3'd2;
      M0_ARBURST = 2'd1; M1_ARBURST = 2'd1;
      S_ARREADY = 1'b1;
      S_RVALID = 0; S_RID = 0; S_RDATA = 0;
      S_RRESP = 0; S_RLAST = 0;
      forever begin
         @(negedge ACLK);
         ar_hs = S_ARVALID & S_ARREADY;
         r_hs  = S_RVALID & S_RREADY;
         m0_hs = M0_ARVALID & M0_ARREADY;
         m1_hs = M1_ARVALID & M1_ARREADY;
         c_id = S_ARID; c_addr = S_ARADDR; c_len = S_ARLEN;
         @(posedge ACLK); #1;
         if (!ARESETn) begin
            S_RVALID = 0;
            M0_ARVALID = 0;
            M1_ARVALID = 0;
            continue;
         end
         if (r_hs) begin
            if (beat == int'(sl_len)) S_RVALID = 0;
            else beat++;
         end
         if (ar_hs) begin
            sl_id = c_id; sl_addr = c_addr; sl_len = c_len;
            beat = 0;
            S_RVALID = 1;
         end
         S_RID   = sl_id | 8'hE0;
         S_RDATA = 32'hA000_0000 + sl_addr + 32'(beat * 4);
         S_RRESP = (sl_addr == 32'h3000) ? 2'b11 : 2'b00;
         S_RLAST = (beat == int'(sl_len));
         if (m0_hs) M0_ARVALID = 0;
         if (m1_hs) M1_ARVALID = 0;
         if (!M0_ARVALID && q0.size() > 0) begin
            r = q0.pop_front();
            M0_ARID = r.id; M0_ARADDR = r.addr; M0_ARLEN = r.len;
            M0_ARVALID = 1;
         end
         if (!M1_ARVALID && q1.size() > 0) begin
            r = q1.pop_front();
            M1_ARID = r.id; M1_ARADDR = r.addr; M1_ARLEN = r.len;
            M1_ARVALID = 1;
         end
      end
   end

   // Monitor: compares every AR and R handshake against the queues.
   initial begin
      beat_t e;
      ar_t   a;
      forever begin
         @(negedge ACLK);
         if (ARESETn) begin
            if (S_ARVALID && S_ARREADY) begin
               if (ar_exp.size() == 0) begin
                  total++; bad++;
                  $display("FAIL ar_unexp: got id %0h", S_ARID);
               end else begin
                  a = ar_exp.pop_front();
                  chk("ar", {S_ARID, S_ARADDR, S_ARLEN},
                      {a.id, a.addr, a.len});
                  chk("ar_attr", {S_ARSIZE, S_ARBURST}, 5'b010_01);
               end
            end
            if (M0_RVALID && M0_RREADY) begin
               if (rexp0.size() == 0) begin
                  total++; bad++;
                  $display("FAIL m0_unexp: got %0h", M0_RDATA);
               end else begin
                  e = rexp0.pop_front();
                  chk("m0_beat",
                      {M0_RID, M0_RRESP, M0_RLAST, M0_RDATA},
                      {e.id, e.resp, e.last, e.data});
               end
               m0_cnt++;
            end
            if (M1_RVALID && M1_RREADY) begin
               if (rexp1.size() == 0) begin
                  total++; bad++;
                  $display("FAIL m1_unexp: got %0h", M1_RDATA);
               end else begin
                  e = rexp1.pop_front();
                  chk("m1_beat",
                      {M1_RID, M1_RRESP, M1_RLAST, M1_RDATA},
                      {e.id, e.resp, e.last, e.data});
               end
               m1_cnt++;
            end
         end
      end
   end

   initial begin
      int  base;
      logic hit;
      ARESETn = 1'b0;
      M0_RREADY = 1'b1;
      M1_RREADY = 1'b1;
      repeat (3) @(negedge ACLK);
      #1;
      chk("rst_outs", any_out, 0);
      @(posedge ACLK); #2;
      ARESETn = 1'b1;

      // single M0 burst with the IDLE bubble
      @(negedge ACLK); #1;
      base = m0_cnt;
      issue(0, 4'h6, 32'h100, 4'd3);
      expect_ar(0, 4'h6, 32'h100, 4'd3);
      @(negedge ACLK); #1;
      chk("t1_bubble", {S_ARVALID, M0_ARREADY}, 0);
      @(negedge ACLK); #1;
      chk("t1_sarvalid", S_ARVALID, 1);
      chk("t1_sarid", S_ARID, 8'h06);
      wait_idle("t1");
      chk("t1_beats", 32'(m0_cnt - base), 4);

      // same-cycle contention after reset
      reset_pulse();
      @(negedge ACLK); #1;
      issue(1, 4'h2, 32'h2000, 4'd1);
      issue(0, 4'h1, 32'h1000, 4'd1);
      expect_ar(0, 4'h1, 32'h1000, 4'd1);
      expect_ar(1, 4'h2, 32'h2000, 4'd1);
      wait_idle("t2");

      // four back-to-back contended bursts
      reset_pulse();
      @(negedge ACLK); #1;
      issue(0, 4'h1, 32'h1000, 4'd1);
      issue(0, 4'h3, 32'h1100, 4'd1);
      issue(1, 4'h2, 32'h2000, 4'd1);
      issue(1, 4'h4, 32'h2100, 4'd1);
      expect_ar(0, 4'h1, 32'h1000, 4'd1);
      expect_ar(1, 4'h2, 32'h2000, 4'd1);
      expect_ar(0, 4'h3, 32'h1100, 4'd1);
      expect_ar(1, 4'h4, 32'h2100, 4'd1);
      wait_idle("t3");
`ifdef ROM_ARB_PERF_EN
      chk("perf_gnt0", PERF_GNT0, 2);
      chk("perf_gnt1", PERF_GNT1, 2);
      chk("perf_stall_nz", PERF_STALL != 0, 1);
`endif

      // DECERR single beat to M1
      @(negedge ACLK); #1;
      issue(1, 4'hA, 32'h3000, 4'd0);
      expect_ar(1, 4'hA, 32'h3000, 4'd0);
      wait_idle("t4");

      // M0 back-pressure with M1 waiting
      @(negedge ACLK); #1;
      base = m0_cnt;
      issue(0, 4'h7, 32'h200, 4'd3);
      expect_ar(0, 4'h7, 32'h200, 4'd3);
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
         @(negedge ACLK); #1;
         hit = (m0_cnt >= base + 2);
      end
      chk("t5_reach", hit, 1);
      @(posedge ACLK); #2;
      M0_RREADY = 1'b0;
      issue(1, 4'h8, 32'h600, 4'd0);
      expect_ar(1, 4'h8, 32'h600, 4'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK); #1;
         chk("t5_hold",
             {S_RREADY, M1_ARREADY, M0_RVALID, M0_RDATA},
             {1'b0, 1'b0, 1'b1, 32'hA000_0208});
      end
      @(posedge ACLK); #2;
      M0_RREADY = 1'b1;
      wait_idle("t5");
      chk("t5_beats", 32'(m0_cnt - base), 4);

      // reset in the middle of an M0 burst
      @(negedge ACLK); #1;
      base = m0_cnt;
      issue(0, 4'h9, 32'h400, 4'd3);
      expect_ar(0, 4'h9, 32'h400, 4'd3);
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
         @(negedge ACLK); #1;
         hit = (m0_cnt >= base + 1);
      end
      chk("t6_reach", hit, 1);
      @(posedge ACLK); #2;
      ARESETn = 1'b0;
      rexp0.delete();
      ar_exp.delete();
      q0.delete();
      @(negedge ACLK); #1;
      chk("t6_rst_outs", any_out, 0);
      repeat (2) @(posedge ACLK);
      #2;
      ARESETn = 1'b1;
      @(negedge ACLK); #1;
      base = m1_cnt;
      issue(1, 4'h5, 32'h500, 4'd1);
      expect_ar(1, 4'h5, 32'h500, 4'd1);
      wait_idle("t6");
      chk("t6_beats", 32'(m1_cnt - base), 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
